param_cpu: RTL and testbench
============================

# param_cpu

Parametrised multicycle successor to the fixed 8-bit, 4-register CPU datapath. Accepts one instruction at a time through a valid/ready handshake. Sequences it through an internal EXEC/MEM/WB state machine over a parametrised register file and data memory. Exposes the register file and ALU flags for observation. Sits at the top of the CPU subsystem, fed by the instruction source / testbench.

## Interface
- DATA_WIDTH, 8, datapath and register width (≥4)
- ADDR_BITS, 5, data memory address width; depth = 2**ADDR_BITS
- NUM_REGS, 4, register count, power of two ≥2; REG_BITS = $clog2(NUM_REGS)
- INSTR_WIDTH (localparam) = 4 + 3*REG_BITS + DATA_WIDTH; default 18
- Instruction fields, MSB first: opcode[4], rd[REG_BITS], rs1[REG_BITS], rs2[REG_BITS], imm[DATA_WIDTH]
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-low reset
- instruction  input  INSTR_WIDTH  instruction word, held stable while instr_valid && !instr_ready
- instr_valid  input  1  instruction offered
- instr_ready  output  1  core idle; transfer on instr_valid && instr_ready at rising clk
- busy  output  1  state != IDLE
- regfile  output  NUM_REGS*DATA_WIDTH  flattened registers, reg i at [i*DATA_WIDTH +: DATA_WIDTH]
- flag_z  output  1  zero flag
- flag_c  output  1  carry/borrow flag
- illegal  output  1  sticky illegal-opcode flag (tied 0 without PARAM_CPU_TRAP_EN)

## Operation
- Opcodes: 0 NOP; 1 ADD rd=rs1+rs2; 2 SUB rd=rs1-rs2; 3 AND; 4 OR; 5 XOR; 6 SHL rd=rs1<<1; 7 SHR rd=rs1>>1 (logical); 8 ADDI rd=rs1+imm; 9 LOAD rd=mem[rs1+imm]; 10 STORE mem[rs1+imm]=rs2; 11 LDI rd=imm; 12 MOV rd=rs1; 13 CMP flags of rs1-rs2, no write; 14–15 reserved.
- Arithmetic is modulo 2**DATA_WIDTH. Memory address = (rs1+imm)[ADDR_BITS-1:0], wrapping.
- Flags:
  - ADD/ADDI: C = carry-out. SUB/CMP: C = borrow (rs1<rs2). SHL/SHR: C = bit shifted out. Z = (result==0) for all of these.
  - AND/OR/XOR/MOV: Z updated, C cleared.
  - NOP/LDI/LOAD/STORE: flags unchanged.
- All registers are general purpose; r0 is not hardwired.
- FSM states: IDLE → EXEC on accept.
  - EXEC → WB for ALU ops and LDI.
  - EXEC → MEM for LOAD/STORE.
  - EXEC → IDLE for NOP and CMP.
  - MEM → WB for LOAD; MEM → IDLE for STORE.
  - WB → IDLE.
- The instruction is latched at accept. Operands are read from the register file in EXEC. Sequential execution means there are no hazards.
- Memory has a synchronous read in MEM and a synchronous write at the end of MEM (STORE only). Memory contents are not reset.

## Timing
- Reset (async assert, sync-safe deassert use):
  - State=IDLE; all registers 0; flag_z=0, flag_c=0, illegal=0; instr_ready=1, busy=0.
  - An in-flight STORE is aborted with no memory write. An in-flight register write is discarded.
- Accept at edge E0. EXEC in the following cycle; ALU result and flags are registered at E1.
- ALU/LDI: register write at E2; result visible on regfile after E2; instr_ready=1 in the cycle after E2. Issue interval 3 cycles.
- LOAD: data read at E2, register write at E3. Interval 4.
- STORE: memory write at E2. Interval 3.
- NOP/CMP: flags (CMP) at E1. Interval 2.
- instr_ready is combinational from state only (== IDLE). It never depends on instr_valid.

## Configuration
- PARAM_CPU_TRAP_EN defined:
  - Opcodes 14–15 set illegal=1 at E1 and enter state HALT.
  - In HALT, instr_ready=0 and busy=1 until reset.
- PARAM_CPU_TRAP_EN undefined:
  - Opcodes 14–15 execute as NOP (interval 2); illegal is tied 0; HALT is not built.

## Structure
- Package param_cpu_pkg:
  - opcode enum (4-bit);
  - state enum {IDLE, EXEC, MEM, WB, HALT};
  - field-offset helper functions parametrised on REG_BITS/DATA_WIDTH.
- Sub-module param_cpu_alu: combinational op → result, next Z, next C, flag-update enable. The register, FSM and memory stay in param_cpu.

## Test plan
- Reset, then LDI r1=0x05, LDI r2=0x03, ADD r3=r1+r2 → r3=0x08, Z=0, C=0; each accept spaced 3 cycles by instr_ready.
- LDI r1=0xFF, ADDI r2=r1+0x01 → r2=0x00, Z=1, C=1. Then SUB r3=r2-r1 → r3=0x01, C=1 (borrow).
- LDI r1=0x1E, STORE mem[r1+0x03]=r2 with r2=0xA5 (address 0x21 wraps to 0x01). LOAD r3=mem[r0+0x01] → r3=0xA5; LOAD interval 4 cycles.
- Hold instr_valid=1 continuously → exactly one accept per idle cycle; instruction changes mid-EXEC are ignored.
- Assert rst during MEM of a STORE to address 0x04 (prior contents 0x11) → all registers 0, state IDLE, mem[0x04] still 0x11.
- Opcode 15 with PARAM_CPU_TRAP_EN → illegal=1 and instr_ready=0 held until reset. Without the macro → behaves as NOP, ready after 2 cycles.

Source files
------------

// File: rtl/param_cpu_pkg.sv
// Shared types and instruction-field helpers for the parametrised multicycle CPU.
package param_cpu_pkg;

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_ADD   = 4'd1,
        OP_SUB   = 4'd2,
        OP_AND   = 4'd3,
        OP_OR    = 4'd4,
        OP_XOR   = 4'd5,
        OP_SHL   = 4'd6,
        OP_SHR   = 4'd7,
        OP_ADDI  = 4'd8,
        OP_LOAD  = 4'd9,
        OP_STORE = 4'd10,
        OP_LDI   = 4'd11,
        OP_MOV   = 4'd12,
        OP_CMP   = 4'd13,
        OP_RSV14 = 4'd14,
        OP_RSV15 = 4'd15
    } opcode_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_e;

    localparam int OPC_BITS = 4;

    function automatic int instr_width(input int rb, input int dw);
        return OPC_BITS + 3 * rb + dw;
    endfunction

    function automatic int opc_lsb(input int rb, input int dw);
        return 3 * rb + dw;
    endfunction

    function automatic int rd_lsb(input int rb, input int dw);
        return 2 * rb + dw;
    endfunction

    function automatic int rs1_lsb(input int rb, input int dw);
        return rb + dw;
    endfunction

    function automatic int rs2_lsb(input int dw);
        return dw;
    endfunction

endpackage

// File: rtl/param_cpu_alu.sv
// Combinational ALU: result, next flags and flag-update enable per opcode.
// Also forms the rs1+imm memory address for LOAD/STORE.
module param_cpu_alu
    import param_cpu_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  opcode_e                 op,
    input  logic [DATA_WIDTH-1:0]   a,
    input  logic [DATA_WIDTH-1:0]   b,
    input  logic [DATA_WIDTH-1:0]   imm,
    output logic [DATA_WIDTH-1:0]   result,
    output logic                    z_next,
    output logic                    c_next,
    output logic                    flag_en
);

    logic [DATA_WIDTH:0] sum;

    always_comb begin
        sum     = '0;
        result  = '0;
        c_next  = 1'b0;
        flag_en = 1'b0;
        unique case (op)
            OP_ADD: begin
                sum     = {1'b0, a} + {1'b0, b};
                result  = sum[DATA_WIDTH-1:0];
                c_next  = sum[DATA_WIDTH];
                flag_en = 1'b1;
            end
            OP_SUB, OP_CMP: begin
                // borrow lands in the extra top bit
                sum     = {1'b0, a} - {1'b0, b};
                result  = sum[DATA_WIDTH-1:0];
                c_next  = sum[DATA_WIDTH];
                flag_en = 1'b1;
            end
            OP_AND: begin
                result  = a & b;
                flag_en = 1'b1;
            end
            OP_OR: begin
                result  = a | b;
                flag_en = 1'b1;
            end
            OP_XOR: begin
                result  = a ^ b;
                flag_en = 1'b1;
            end
            OP_MOV: begin
                result  = a;
                flag_en = 1'b1;
            end
            OP_SHL: begin
                result  = {a[DATA_WIDTH-2:0], 1'b0};
                c_next  = a[DATA_WIDTH-1];
                flag_en = 1'b1;
            end
            OP_SHR: begin
                result  = {1'b0, a[DATA_WIDTH-1:1]};
                c_next  = a[0];
                flag_en = 1'b1;
            end
            OP_ADDI, OP_LOAD, OP_STORE: begin
                sum     = {1'b0, a} + {1'b0, imm};
                result  = sum[DATA_WIDTH-1:0];
                c_next  = sum[DATA_WIDTH];
                flag_en = (op == OP_ADDI);
            end
            OP_LDI: begin
                result = imm;
            end
            default: begin
                result = '0;
            end
        endcase
    end

    assign z_next = (result == '0);

endmodule

// File: rtl/param_cpu.sv
// Parametrised multicycle CPU: handshake intake, EXEC/MEM/WB sequencing.
// Define PARAM_CPU_TRAP_EN to trap reserved opcodes into a sticky HALT.
module param_cpu
    import param_cpu_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_BITS  = 5,
    parameter int NUM_REGS   = 4,
    localparam int REG_BITS    = $clog2(NUM_REGS),
    localparam int INSTR_WIDTH = instr_width(REG_BITS, DATA_WIDTH)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [INSTR_WIDTH-1:0]         instruction,
    input  logic                           instr_valid,
    output logic                           instr_ready,
    output logic                           busy,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regfile,
    output logic                           flag_z,
    output logic                           flag_c,
    output logic                           illegal
);

    localparam int OPC_LSB = opc_lsb(REG_BITS, DATA_WIDTH);
    localparam int RD_LSB  = rd_lsb(REG_BITS, DATA_WIDTH);
    localparam int RS1_LSB = rs1_lsb(REG_BITS, DATA_WIDTH);
    localparam int RS2_LSB = rs2_lsb(DATA_WIDTH);
    localparam int DEPTH   = 2 ** ADDR_BITS;

    state_e                  state;
    opcode_e                 op_q;
    logic [REG_BITS-1:0]     rd_q;
    logic [REG_BITS-1:0]     rs1_q;
    logic [REG_BITS-1:0]     rs2_q;
    logic [DATA_WIDTH-1:0]   imm_q;
    logic [DATA_WIDTH-1:0]   res_q;
    logic [DATA_WIDTH-1:0]   mem_q;
    logic [DATA_WIDTH-1:0]   regs [NUM_REGS];
    logic [DATA_WIDTH-1:0]   mem  [DEPTH];

    logic [DATA_WIDTH-1:0]   alu_res;
    logic                    alu_z;
    logic                    alu_c;
    logic                    alu_fen;
    logic [ADDR_BITS-1:0]    mem_addr;

    logic                    is_mem;
    logic                    is_wb;
    logic                    is_rsv;

    param_cpu_alu #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_alu (
        .op      (op_q),
        .a       (regs[rs1_q]),
        .b       (regs[rs2_q]),
        .imm     (imm_q),
        .result  (alu_res),
        .z_next  (alu_z),
        .c_next  (alu_c),
        .flag_en (alu_fen)
    );

    assign is_mem = (op_q == OP_LOAD) || (op_q == OP_STORE);
    assign is_rsv = (op_q == OP_RSV14) || (op_q == OP_RSV15);
    assign is_wb  = (op_q inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
                                  OP_SHL, OP_SHR, OP_ADDI, OP_LDI, OP_MOV});

    assign mem_addr    = res_q[ADDR_BITS-1:0];
    assign instr_ready = (state == S_IDLE);
    assign busy        = (state != S_IDLE);

`ifdef PARAM_CPU_TRAP_EN
    logic illegal_q;
    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            op_q   <= OP_NOP;
            rd_q   <= '0;
            rs1_q  <= '0;
            rs2_q  <= '0;
            imm_q  <= '0;
            res_q  <= '0;
            flag_z <= 1'b0;
            flag_c <= 1'b0;
`ifdef PARAM_CPU_TRAP_EN
            illegal_q <= 1'b0;
`endif
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (instr_valid) begin
                        op_q  <= opcode_e'(instruction[OPC_LSB +: OPC_BITS]);
                        rd_q  <= instruction[RD_LSB +: REG_BITS];
                        rs1_q <= instruction[RS1_LSB +: REG_BITS];
                        rs2_q <= instruction[RS2_LSB +: REG_BITS];
                        imm_q <= instruction[0 +: DATA_WIDTH];
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    res_q <= alu_res;
                    if (alu_fen) begin
                        flag_z <= alu_z;
                        flag_c <= alu_c;
                    end
                    unique case (1'b1)
                        is_mem: state <= S_MEM;
                        is_wb:  state <= S_WB;
`ifdef PARAM_CPU_TRAP_EN
                        is_rsv: begin
                            state     <= S_HALT;
                            illegal_q <= 1'b1;
                        end
`endif
                        default: state <= S_IDLE;
                    endcase
                end
                S_MEM: begin
                    state <= (op_q == OP_LOAD) ? S_WB : S_IDLE;
                end
                S_WB: begin
                    regs[rd_q] <= (op_q == OP_LOAD) ? mem_q : res_q;
                    state      <= S_IDLE;
                end
`ifdef PARAM_CPU_TRAP_EN
                S_HALT: begin
                    state <= S_HALT;
                end
`endif
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Memory is not reset; reset forces IDLE so an in-flight STORE never writes.
    always_ff @(posedge clk) begin
        if (state == S_MEM) begin
            if (op_q == OP_STORE) begin
                mem[mem_addr] <= regs[rs2_q];
            end
            mem_q <= mem[mem_addr];
        end
    end

    always_comb begin
        regfile = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            regfile[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
        end
    end

endmodule

// File: tb/tb_param_cpu.sv
// Directed self-checking bench for param_cpu (default parameters).
module tb_param_cpu;

    logic        clk;
    logic        rst;
    logic [17:0] instruction;
    logic        instr_valid;
    logic        instr_ready;
    logic        busy;
    logic [31:0] regfile;
    logic        flag_z;
    logic        flag_c;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    param_cpu dut (
        .clk         (clk),
        .rst         (rst),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .busy        (busy),
        .regfile     (regfile),
        .flag_z      (flag_z),
        .flag_c      (flag_c),
        .illegal     (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    function automatic logic [17:0] mk(input logic [3:0] op, input logic [1:0] rd,
                                       input logic [1:0] rs1, input logic [1:0] rs2,
                                       input logic [7:0] imm);
        return {op, rd, rs1, rs2, imm};
    endfunction

    function automatic logic [7:0] rf(input int i);
        return regfile[i*8 +: 8];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where instr_ready is back.
    task automatic send(input string tag, input logic [17:0] ins, input int exp_n);
        int n;
        n = 0;
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        instruction = ins;
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (instr_ready) break;
        end
        check({tag, "_interval"}, n, exp_n);
    endtask

    int acc;

    initial begin
        rst = 1'b0;
        instruction = '0;
        instr_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_regs", regfile, 32'h0);
        check("rst_ready", instr_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_flags", {flag_z, flag_c}, 2'b00);
        check("rst_illegal", illegal, 0);
        rst = 1'b1;
        @(negedge clk);

        send("ldi_r1", mk(4'd11, 2'd1, 2'd0, 2'd0, 8'h05), 3);
        send("ldi_r2", mk(4'd11, 2'd2, 2'd0, 2'd0, 8'h03), 3);
        send("add", mk(4'd1, 2'd3, 2'd1, 2'd2, 8'h00), 3);
        check("add_r3", rf(3), 8'h08);
        check("add_flags", {flag_z, flag_c}, 2'b00);

        send("ldi_ff", mk(4'd11, 2'd1, 2'd0, 2'd0, 8'hFF), 3);
        send("addi", mk(4'd8, 2'd2, 2'd1, 2'd0, 8'h01), 3);
        check("addi_r2", rf(2), 8'h00);
        check("addi_flags", {flag_z, flag_c}, 2'b11);
        send("sub", mk(4'd2, 2'd3, 2'd2, 2'd1, 8'h00), 3);
        check("sub_r3", rf(3), 8'h01);
        check("sub_flags", {flag_z, flag_c}, 2'b01);

        send("ldi_1e", mk(4'd11, 2'd1, 2'd0, 2'd0, 8'h1E), 3);
        send("ldi_a5", mk(4'd11, 2'd2, 2'd0, 2'd0, 8'hA5), 3);
        send("store_wrap", mk(4'd10, 2'd0, 2'd1, 2'd2, 8'h03), 3);
        send("load_wrap", mk(4'd9, 2'd3, 2'd0, 2'd0, 8'h01), 4);
        check("load_r3", rf(3), 8'hA5);
        check("load_flags_kept", {flag_z, flag_c}, 2'b01);

        instruction = mk(4'd11, 2'd1, 2'd0, 2'd0, 8'h10);
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instruction = mk(4'd11, 2'd1, 2'd0, 2'd0, 8'h20);
        @(negedge clk);
        check("hold_exec_ready", instr_ready, 0);
        check("hold_exec_busy", busy, 1);
        @(negedge clk);
        @(negedge clk);
        check("hold_first_r1", rf(1), 8'h10);
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            if (instr_ready) acc++;
            @(negedge clk);
        end
        instr_valid = 1'b0;
        check("hold_accepts", acc, 2);
        check("hold_last_r1", rf(1), 8'h20);

        send("ldi_3", mk(4'd11, 2'd1, 2'd0, 2'd0, 8'h03), 3);
        send("ldi_5", mk(4'd11, 2'd2, 2'd0, 2'd0, 8'h05), 3);
        send("cmp_lt", mk(4'd13, 2'd3, 2'd1, 2'd2, 8'h00), 2);
        check("cmp_lt_flags", {flag_z, flag_c}, 2'b01);
        check("cmp_no_write", rf(3), 8'hA5);
        send("cmp_gt", mk(4'd13, 2'd3, 2'd2, 2'd1, 8'h00), 2);
        check("cmp_gt_flags", {flag_z, flag_c}, 2'b00);

        send("ldi_81", mk(4'd11, 2'd1, 2'd0, 2'd0, 8'h81), 3);
        send("shl", mk(4'd6, 2'd2, 2'd1, 2'd0, 8'h00), 3);
        check("shl_r2", rf(2), 8'h02);
        check("shl_flags", {flag_z, flag_c}, 2'b01);
        send("shr", mk(4'd7, 2'd3, 2'd1, 2'd0, 8'h00), 3);
        check("shr_r3", rf(3), 8'h40);
        check("shr_flags", {flag_z, flag_c}, 2'b01);
        send("xor", mk(4'd5, 2'd1, 2'd1, 2'd1, 8'h00), 3);
        check("xor_r1", rf(1), 8'h00);
        check("xor_flags", {flag_z, flag_c}, 2'b10);

        send("ldi_4", mk(4'd11, 2'd1, 2'd0, 2'd0, 8'h04), 3);
        send("ldi_11", mk(4'd11, 2'd2, 2'd0, 2'd0, 8'h11), 3);
        send("store_11", mk(4'd10, 2'd0, 2'd1, 2'd2, 8'h00), 3);
        send("ldi_99", mk(4'd11, 2'd2, 2'd0, 2'd0, 8'h99), 3);
        instruction = mk(4'd10, 2'd0, 2'd1, 2'd2, 8'h00);
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("abort_in_mem", busy, 1);
        rst = 1'b0;
        #1;
        check("abort_regs", regfile, 32'h0);
        check("abort_ready", instr_ready, 1);
        check("abort_busy", busy, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        send("load_kept", mk(4'd9, 2'd3, 2'd0, 2'd0, 8'h04), 4);
        check("abort_mem_kept", rf(3), 8'h11);

`ifdef PARAM_CPU_TRAP_EN
        instruction = mk(4'd15, 2'd1, 2'd0, 2'd0, 8'h00);
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("trap_illegal", illegal, 1);
        check("trap_ready", instr_ready, 0);
        check("trap_busy", busy, 1);
        rst = 1'b0;
        #1;
        check("trap_clr_illegal", illegal, 0);
        check("trap_clr_ready", instr_ready, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
`else
        send("rsv15_nop", mk(4'd15, 2'd3, 2'd0, 2'd0, 8'h00), 2);
        check("rsv15_illegal", illegal, 0);
        check("rsv15_no_write", rf(3), 8'h11);
        check("rsv15_flags", {flag_z, flag_c}, 2'b00);
`endif
        send("post_ldi", mk(4'd11, 2'd0, 2'd0, 2'd0, 8'h5A), 3);
        check("post_r0", rf(0), 8'h5A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
